// File: rtl/hsstl_rst4mcrsw_pkg.sv
// Shared encodings for the HSST TX rate scheduler: FSM states and lane rate values.
package hsstl_rst4mcrsw_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StApply   = 3'd1,
    StHold    = 3'd2,
    StCheck   = 3'd3,
    StDone    = 3'd4,
    StPllWait = 3'd5
  } sched_state_e;

  localparam logic RateFull = 1'b1;
  localparam logic RateHalf = 1'b0;

endpackage

// File: rtl/hsstl_rst4mcrsw_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping to lane 0.
module hsstl_rst4mcrsw_rr_arb #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    logic [IW-1:0] j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IW'((32'(ptr) + k) % N);
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/hsstl_rst4mcrsw_tx_rate_sched.sv
// Serialises TX rate changes across lanes sharing one PLL: one lane at a time, round-robin,
// only while the PLL is ready and the target lane reports reset done.
module hsstl_rst4mcrsw_tx_rate_sched
  import hsstl_rst4mcrsw_pkg::*;
#(
  parameter int unsigned LANE_NUM       = 4,
  parameter int unsigned CNTR_WIDTH     = 12,
  parameter int unsigned HOLD_CYCLES    = 256,
  parameter int unsigned TIMEOUT_CYCLES = 4000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pll_ready,
  input  logic [LANE_NUM-1:0] lane_rst_done,
  input  logic [LANE_NUM-1:0] rate_req,
  output logic [LANE_NUM-1:0] lane_rate,
  output logic [LANE_NUM-1:0] grant,
  output logic                busy,
  output logic                err_timeout,
  output logic [2:0]          sched_state
);

  localparam int unsigned IdxW = (LANE_NUM > 1) ? $clog2(LANE_NUM) : 1;
  localparam logic [CNTR_WIDTH-1:0] HoldLast    = CNTR_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNTR_WIDTH-1:0] TimeoutLast = CNTR_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [IdxW-1:0]       LastLane    = IdxW'(LANE_NUM - 1);

  sched_state_e        state_q, state_d;
  logic [LANE_NUM-1:0] rate_q, rate_d;
  logic [LANE_NUM-1:0] grant_q, grant_d;
  logic [IdxW-1:0]     g_q, g_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [CNTR_WIDTH-1:0] cntr_q, cntr_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic [LANE_NUM-1:0] eligible;
  logic [LANE_NUM-1:0] arb_gnt;
  logic [IdxW-1:0]     arb_idx;
  logic                arb_any;

  // A lane is pending while its requested rate differs from what we currently drive.
  assign eligible = (rate_req ^ rate_q) & lane_rst_done;

  hsstl_rst4mcrsw_rr_arb #(
    .N  (LANE_NUM),
    .IW (IdxW)
  ) u_rr_arb (
    .req (eligible),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    state_d = state_q;
    rate_d  = rate_q;
    grant_d = grant_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    cntr_d  = cntr_q;
    busy_d  = busy_q;
    err_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (pll_ready && arb_any) begin
          grant_d = arb_gnt;
          g_d     = arb_idx;
          busy_d  = 1'b1;
          state_d = StApply;
        end
      end
      StApply: begin
        rate_d[g_q] = rate_req[g_q];
        cntr_d      = '0;
        state_d     = StHold;
      end
      StHold: begin
        if (!pll_ready) begin
          grant_d = '0;
          busy_d  = 1'b1;
          cntr_d  = '0;
          state_d = StPllWait;
        end else if (cntr_q == HoldLast) begin
          cntr_d  = '0;
          state_d = StCheck;
        end else begin
          cntr_d = cntr_q + 1'b1;
        end
      end
      StCheck: begin
        if (!pll_ready) begin
          grant_d = '0;
          busy_d  = 1'b1;
          cntr_d  = '0;
          state_d = StPllWait;
        end else if (lane_rst_done[g_q]) begin
          state_d = StDone;
        end else if (cntr_q == TimeoutLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cntr_d = cntr_q + 1'b1;
        end
      end
      StDone: begin
        grant_d = '0;
        busy_d  = 1'b0;
        ptr_d   = (g_q == LastLane) ? '0 : g_q + 1'b1;
        state_d = StIdle;
      end
      StPllWait: begin
        // Lane FSM redoes its full PLL reset with the already-applied rate; just wait.
        if (pll_ready) begin
          state_d = StDone;
        end
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rate_q  <= {LANE_NUM{RateHalf}};
      grant_q <= '0;
      g_q     <= '0;
      ptr_q   <= '0;
      cntr_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rate_q  <= rate_d;
      grant_q <= grant_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      cntr_q  <= cntr_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign lane_rate   = rate_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;
  assign sched_state = state_q;

endmodule

// File: tb/tb_hsstl_rst4mcrsw_tx_rate_sched.sv
// Self-checking bench: timeline-based reference model compared every cycle, plus directed literals.
module tb_hsstl_rst4mcrsw_tx_rate_sched;

  localparam int L    = 4;
  localparam int HOLD = 256;
  localparam int TMO  = 4000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pll_ready = 1'b1;
  logic [L-1:0] lane_rst_done = 4'hF;
  logic [L-1:0] rate_req = 4'h0;
  logic [L-1:0] lane_rate, grant;
  logic         busy, err_timeout;
  logic [2:0]   sched_state;

  hsstl_rst4mcrsw_tx_rate_sched #(
    .LANE_NUM       (L),
    .CNTR_WIDTH     (12),
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_ready     (pll_ready),
    .lane_rst_done (lane_rst_done),
    .rate_req      (rate_req),
    .lane_rate     (lane_rate),
    .grant         (grant),
    .busy          (busy),
    .err_timeout   (err_timeout),
    .sched_state   (sched_state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a grant is a timeline measured in cycles since it was issued.
  // age 0 = rate being applied, 1..HOLD = hold window, beyond = waiting for lane done.
  int         m_lane = -1;
  int         m_age = 0;
  bit         m_wait = 0;
  bit         m_fin = 0;
  int         m_ptr = 0;
  bit         m_err = 0;
  logic [L-1:0] m_rate = '0;

  task automatic model_reset();
    m_lane = -1; m_age = 0; m_wait = 0; m_fin = 0; m_ptr = 0; m_err = 0; m_rate = '0;
  endtask

  task automatic model_step(input bit pll, input logic [L-1:0] done, input logic [L-1:0] req);
    logic [L-1:0] elig;
    m_err = 0;
    if (m_lane < 0) begin
      elig = (req ^ m_rate) & done;
      if (pll && elig != 0) begin
        for (int k = 0; k < L; k++) begin
          int j;
          j = (m_ptr + k) % L;
          if (m_lane < 0 && elig[j]) m_lane = j;
        end
        m_age = 0; m_wait = 0; m_fin = 0;
      end
    end else if (m_fin) begin
      m_ptr  = (m_lane + 1) % L;
      m_lane = -1;
    end else if (m_wait) begin
      if (pll) m_fin = 1;
    end else if (m_age == 0) begin
      m_rate[m_lane] = req[m_lane];
      m_age = 1;
    end else if (!pll) begin
      m_wait = 1;
    end else if (m_age > HOLD) begin
      if (done[m_lane]) m_fin = 1;
      else if (m_age - HOLD == TMO) begin
        m_err = 1; m_fin = 1;
      end else m_age++;
    end else begin
      m_age++;
    end
  endtask

  int         order_q[$];
  logic [L-1:0] prev_grant = '0;

  always @(posedge clk) begin
    logic [L-1:0] e_grant;
    logic [2:0]   e_state;
    if (!rst_n) model_reset();
    else model_step(pll_ready, lane_rst_done, rate_req);
    e_grant = '0;
    if (m_lane >= 0 && !m_wait) e_grant[m_lane] = 1'b1;
    if (m_lane < 0) e_state = 3'd0;
    else if (m_fin) e_state = 3'd4;
    else if (m_wait) e_state = 3'd5;
    else if (m_age == 0) e_state = 3'd1;
    else if (m_age <= HOLD) e_state = 3'd2;
    else e_state = 3'd3;
    #1;
    chk("model_lane_rate", lane_rate, m_rate);
    chk("model_grant", grant, e_grant);
    chk("model_busy", busy, m_lane >= 0);
    chk("model_err", err_timeout, m_err);
    chk("model_state", sched_state, e_state);
    chk("grant_onehot", $countones(grant) <= 1, 1);
    if (grant != 0 && prev_grant == 0) begin
      for (int i = 0; i < L; i++) if (grant[i]) order_q.push_back(i);
    end
    prev_grant = grant;
  end

  task automatic wait_grant(input int lane, input int bound, input string name);
    int k;
    logic [L-1:0] want;
    want = '0;
    want[lane] = 1'b1;
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (grant !== want && k < bound);
    chk(name, grant, want);
  endtask

  task automatic wait_idle(input int bound, input string name);
    int k;
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while ((busy !== 1'b0 || grant !== '0) && k < bound);
    chk(name, busy, 0);
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_lane_rate", lane_rate, 0);
    chk("reset_grant", grant, 0);
    chk("reset_busy", busy, 0);
    chk("reset_state", sched_state, 0);

    // Idle with nothing pending.
    repeat (20) @(posedge clk);
    #1;
    chk("idle_grant", grant, 0);
    chk("idle_lane_rate", lane_rate, 0);

    // Toggle and back while PLL not ready: no change issued.
    @(negedge clk); pll_ready = 1'b0; rate_req = 4'b0001;
    repeat (3) @(negedge clk);
    rate_req = 4'b0000;
    @(negedge clk); pll_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("toggle_back_busy", busy, 0);
    chk("toggle_back_rate", lane_rate, 0);

    // Two lanes requested: lane0 first, then lane2.
    @(negedge clk); rate_req = 4'b0101;
    @(posedge clk); #1;
    chk("basic_grant_t1", grant, 4'b0001);
    chk("basic_rate_t1", lane_rate, 4'b0000);
    @(posedge clk); #1;
    chk("basic_rate_t2", lane_rate, 4'b0001);
    cyc = 1;
    while (grant !== 4'b0100 && cyc < 1000) begin
      @(posedge clk); #1; cyc++;
    end
    chk("basic_grant_gap", cyc, HOLD + 4);
    @(posedge clk); #1;
    chk("basic_rate_final", lane_rate, 4'b0101);
    wait_idle(2000, "basic_idle");

    // Fresh start; serve lane1 twice so the pointer lands on lane2.
    @(negedge clk); rst_n = 1'b0; rate_req = 4'b0000;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); rate_req = 4'b0010;
    wait_grant(1, 10, "rr_prep_grant_a");
    wait_idle(2000, "rr_prep_idle_a");
    @(negedge clk); rate_req = 4'b0000;
    wait_grant(1, 10, "rr_prep_grant_b");
    wait_idle(2000, "rr_prep_idle_b");
    order_q.delete();
    @(negedge clk); rate_req = 4'b1111;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while ((order_q.size() < 4 || busy) && cyc < 3000);
    chk("rr_count", order_q.size(), 4);
    if (order_q.size() == 4) begin
      chk("rr_order0", order_q[0], 2);
      chk("rr_order1", order_q[1], 3);
      chk("rr_order2", order_q[2], 0);
      chk("rr_order3", order_q[3], 1);
    end
    chk("rr_rate", lane_rate, 4'b1111);

    // Lane1 not reset-done: skipped this round, served once done rises.
    order_q.delete();
    @(negedge clk); lane_rst_done = 4'b1101; rate_req = 4'b0000;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while ((order_q.size() < 3 || busy) && cyc < 3000);
    repeat (10) @(posedge clk);
    #1;
    chk("skip_busy", busy, 0);
    chk("skip_rate", lane_rate, 4'b0010);
    chk("skip_count", order_q.size(), 3);
    @(negedge clk); lane_rst_done = 4'b1111;
    wait_grant(1, 10, "skip_late_grant");
    wait_idle(2000, "skip_idle");
    chk("skip_rate_final", lane_rate, 4'b0000);

    // Granted lane never reports done: timeout pulse.
    @(negedge clk); rate_req = 4'b0100;
    wait_grant(2, 10, "tmo_grant");
    @(negedge clk); lane_rst_done = 4'b1011;
    cyc = 0;
    while (err_timeout !== 1'b1 && cyc < 5000) begin
      @(posedge clk); #1; cyc++;
    end
    chk("tmo_latency", cyc, HOLD + TMO + 1);
    chk("tmo_rate", lane_rate, 4'b0100);
    @(posedge clk); #1;
    chk("tmo_pulse_width", err_timeout, 0);
    chk("tmo_grant_clear", grant, 0);
    @(negedge clk); lane_rst_done = 4'b1111;

    // PLL drops during hold.
    @(negedge clk); rate_req = 4'b0000;
    wait_grant(2, 10, "pll_grant");
    repeat (5) @(posedge clk);
    @(negedge clk); pll_ready = 1'b0;
    @(posedge clk); #1;
    chk("pll_state", sched_state, 5);
    chk("pll_grant", grant, 0);
    chk("pll_busy", busy, 1);
    chk("pll_rate", lane_rate, 4'b0000);
    repeat (3) @(posedge clk);
    #1;
    chk("pll_still_busy", busy, 1);
    @(negedge clk); pll_ready = 1'b1;
    @(posedge clk); #1;
    chk("pll_done_state", sched_state, 4);
    @(posedge clk); #1;
    chk("pll_idle_busy", busy, 0);
    chk("pll_idle_state", sched_state, 0);

    // Reset in the middle of a change.
    @(negedge clk); rate_req = 4'b1111;
    wait_grant(3, 10, "rst_grant");
    repeat (5) @(posedge clk);
    #1;
    chk("rst_rate_before", lane_rate, 4'b1000);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("rst_mid_rate", lane_rate, 0);
    chk("rst_mid_grant", grant, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_state", sched_state, 0);
    chk("rst_mid_err", err_timeout, 0);
    repeat (2) @(negedge clk);
    rate_req = 4'b0000;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
